// File: rtl/i2s_rx_multi.sv
// I2S master receiver for MEMS microphone arrays: generates SCK/WS, captures NUM_LINES
// data lines and emits each line's sample as one sign-extended AXI-Stream beat.
module i2s_rx_multi #(
   parameter  int NUM_LINES   = 2,
   parameter  int SAMPLE_BITS = 24,
   parameter  int SLOT_BITS   = 32,
   parameter  int SCK_DIV     = 4,
   localparam int LINE_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
   input  logic                 m_axis_aclk,
   input  logic                 m_axis_aresetn,
   output logic                 SCK,
   output logic                 WS,
   input  logic [NUM_LINES-1:0] SD,
   input  logic                 frame_sync,
   output logic [31:0]          m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic [LINE_W+1:0]    m_axis_tuser,
   output logic [15:0]          overflow_cnt
);

   localparam int DIV_W = $clog2(SCK_DIV);
   localparam int BIT_W = $clog2(SLOT_BITS);
   localparam int IDX_W = LINE_W + 1;

   if (NUM_LINES < 1 || NUM_LINES > 16 || SAMPLE_BITS < 8 || SAMPLE_BITS > 32 ||
       SLOT_BITS < SAMPLE_BITS + 1 || SCK_DIV < 2 ||
       NUM_LINES >= 2 * SCK_DIV * (SLOT_BITS - SAMPLE_BITS)) begin : g_bad_params
      $error("i2s_rx_multi: illegal parameter combination");
   end

   logic [DIV_W-1:0]              div_cnt;
   logic [BIT_W-1:0]              bit_cnt;
   logic [IDX_W-1:0]              nxt_idx;
   logic                          bank_full;
   logic                          bank_ws;
   logic                          bank_sof;
   logic                          sof_pending;
   logic [SAMPLE_BITS-1:0]        shreg [NUM_LINES];
   logic signed [SAMPLE_BITS-1:0] bank  [NUM_LINES];

   logic sck_tick, sck_rise, sck_fall;
   logic slot_done, last_accept, bank_load, sof_take;

   assign sck_tick    = (div_cnt == DIV_W'(SCK_DIV - 1));
   assign sck_rise    = sck_tick && !SCK;
   assign sck_fall    = sck_tick && SCK;
   assign slot_done   = sck_rise && (bit_cnt == BIT_W'(SAMPLE_BITS));
   // The word in the output register with the last line index is the bank's final word.
   assign last_accept = m_axis_tvalid && m_axis_tready &&
                        (m_axis_tuser[LINE_W-1:0] == LINE_W'(NUM_LINES - 1));
   assign bank_load   = slot_done && (!bank_full || last_accept);
   assign sof_take    = bank_load && !WS && sof_pending;

   // NOTE: shift and bank storage carry no reset; bank_full and the output stage qualify them.
   always_ff @(posedge m_axis_aclk) begin
      for (int i = 0; i < NUM_LINES; i++) begin
         if (sck_rise && bit_cnt != '0 && bit_cnt <= BIT_W'(SAMPLE_BITS))
            shreg[i] <= {shreg[i][SAMPLE_BITS-2:0], SD[i]};
         if (bank_load)
            bank[i] <= {shreg[i][SAMPLE_BITS-2:0], SD[i]};
      end
   end

   // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         div_cnt       <= '0;
         bit_cnt       <= '0;
         SCK           <= 1'b0;
         WS            <= 1'b0;
         nxt_idx       <= '0;
         bank_full     <= 1'b0;
         bank_ws       <= 1'b0;
         bank_sof      <= 1'b0;
         sof_pending   <= 1'b0;
         overflow_cnt  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
      end else begin
         div_cnt <= sck_tick ? '0 : div_cnt + 1'b1;
         if (sck_tick)
            SCK <= ~SCK;
         if (sck_fall) begin
            if (bit_cnt == BIT_W'(SLOT_BITS - 1)) begin
               bit_cnt <= '0;
               WS      <= ~WS;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end

         sof_pending <= frame_sync || (sof_pending && !sof_take);

         if (slot_done && !bank_load && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 1'b1;

         if (m_axis_tvalid && m_axis_tready)
            m_axis_tvalid <= 1'b0;
         if ((!m_axis_tvalid || m_axis_tready) && bank_full && nxt_idx != IDX_W'(NUM_LINES)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= 32'(bank[nxt_idx[LINE_W-1:0]]);
            m_axis_tuser  <= {bank_sof && (nxt_idx == '0), bank_ws, nxt_idx[LINE_W-1:0]};
            nxt_idx       <= nxt_idx + 1'b1;
         end

         // A completing slot may refill the bank on the cycle its last word is taken.
         if (last_accept)
            bank_full <= 1'b0;
         if (bank_load) begin
            bank_full <= 1'b1;
            bank_ws   <= WS;
            bank_sof  <= sof_take;
            nxt_idx   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Bench for i2s_rx_multi: two configurations run side by side against a cycle-arithmetic
// reference model driven by random samples, random backpressure and mid-slot reset.
module tb_i2s_rx_multi;

   logic clk = 1'b0;
   logic rstn;
   logic tready;
   logic fs;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int     NL   = (g == 0) ? 2 : 4;
      localparam int     SB   = (g == 0) ? 24 : 16;
      localparam int     SL   = (g == 0) ? 32 : 24;
      localparam int     DV   = (g == 0) ? 4 : 2;
      localparam int     LW   = (NL > 1) ? $clog2(NL) : 1;
      localparam int     NFIX = (g == 0) ? 1 : 8;
      localparam bit     ALT  = (g == 0);
      localparam longint FIX0 = (g == 0) ? 64'hA5F00F : 64'h8001;
      localparam longint MASK = (longint'(1) << SB) - 1;

      logic          sck, ws, tvalid;
      logic [NL-1:0] sd = '0;
      logic [31:0]   tdata;
      logic [LW+1:0] tuser;
      logic [15:0]   ovf;

      int          n = 0;
      int          words_left = 0;
      int          ovf_m = 0;
      int          vexp = 0;
      bit          in_rst = 1'b0;
      bit          hold = 1'b0;
      bit          pend = 1'b0;
      longint      samp [128][NL];
      logic [31:0] q_data [$];
      logic [31:0] q_user [$];

      i2s_rx_multi #(.NUM_LINES(NL), .SAMPLE_BITS(SB), .SLOT_BITS(SL), .SCK_DIV(DV)) dut (
         .m_axis_aclk   (clk),
         .m_axis_aresetn(rstn),
         .SCK           (sck),
         .WS            (ws),
         .SD            (sd),
         .frame_sync    (fs),
         .m_axis_tdata  (tdata),
         .m_axis_tvalid (tvalid),
         .m_axis_tready (tready),
         .m_axis_tuser  (tuser),
         .overflow_cnt  (ovf)
      );

      function automatic logic [31:0] sext(input longint v);
         longint r;
         r = (v >= (longint'(1) << (SB - 1))) ? v - (longint'(1) << SB) : v;
         return r[31:0];
      endfunction

      // Negedge: first compare the DUT against the model state for the last posedge,
      // then advance the model to the coming posedge and drive SD for it.
      always @(negedge clk) begin
         int  c, k, s, b;
         bit  sof;
         if (in_rst) begin
            check($sformatf("c%0d_rst_sck", g), 32'(sck), 32'd0);
            check($sformatf("c%0d_rst_ws", g), 32'(ws), 32'd0);
            check($sformatf("c%0d_rst_tvalid", g), 32'(tvalid), 32'd0);
            check($sformatf("c%0d_rst_tdata", g), tdata, 32'd0);
            check($sformatf("c%0d_rst_tuser", g), 32'(tuser), 32'd0);
            check($sformatf("c%0d_rst_ovf", g), 32'(ovf), 32'd0);
         end else if (n > 0) begin
            check($sformatf("c%0d_sck", g), 32'(sck), 32'((n / DV) % 2));
            check($sformatf("c%0d_ws", g), 32'(ws), 32'((n / (2 * DV * SL)) % 2));
            check($sformatf("c%0d_ovf", g), 32'(ovf), 32'(ovf_m));
            if (hold)
               check($sformatf("c%0d_valid_held", g), 32'(tvalid), 32'd1);
            if (n == vexp - 1)
               check($sformatf("c%0d_latency_lo", g), 32'(tvalid), 32'd0);
            if (n == vexp)
               check($sformatf("c%0d_latency_hi", g), 32'(tvalid), 32'd1);
            if (tvalid) begin
               check($sformatf("c%0d_beat_expected", g), 32'(q_data.size() != 0), 32'd1);
               if (q_data.size() != 0) begin
                  check($sformatf("c%0d_tdata", g), tdata, q_data[0]);
                  check($sformatf("c%0d_tuser", g), 32'(tuser), q_user[0]);
               end
            end
         end

         if (!rstn) begin
            in_rst = 1'b1;
            n = 0; words_left = 0; ovf_m = 0; vexp = 0; hold = 1'b0; pend = 1'b0;
            q_data.delete();
            q_user.delete();
            for (int si = 0; si < 128; si++)
               for (int i = 0; i < NL; i++)
                  if (si < NFIX)
                     samp[si][i] = (ALT && i % 2 == 1) ? (~FIX0 & MASK) : FIX0;
                  else
                     samp[si][i] = longint'($urandom) & MASK;
         end else begin
            in_rst = 1'b0;
            n++;
            if (tvalid && tready && q_data.size() != 0) begin
               void'(q_data.pop_front());
               void'(q_user.pop_front());
               words_left--;
            end
            hold = tvalid && !tready;
            k = (n / DV - 1) / 2;
            if (n % DV == 0 && (n / DV) % 2 == 1 && k % SL == SB) begin
               s = k / SL;
               if (words_left == 0) begin
                  sof  = (s % 2 == 0) && pend;
                  pend = sof ? fs : (pend || fs);
                  for (int i = 0; i < NL; i++) begin
                     q_data.push_back(sext(samp[s % 128][i]));
                     q_user.push_back(32'(((sof && i == 0) ? 1 : 0) * (1 << (LW + 1)) +
                                          (s % 2) * (1 << LW) + i));
                  end
                  words_left = NL;
                  vexp = n + 1;
               end else begin
                  if (ovf_m < 16'hFFFF) ovf_m++;
                  pend = pend || fs;
               end
            end else begin
               pend = pend || fs;
            end
            // SCK rises on edges DV*(2k+1); present the bit of the next such rise.
            c = (n + DV - 1) / DV;
            k = c / 2;
            s = k / SL;
            b = k % SL;
            for (int i = 0; i < NL; i++)
               if (b >= 1 && b <= SB) sd[i] = samp[s % 128][i][SB - b];
               else                   sd[i] = 1'($urandom);
         end
      end
   end

   task automatic wait_n(input int target);
      for (int i = 0; i < 6000 && cfg[0].n < target; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic expect_first_slot();
      int waited = 0;
      @(negedge clk);
      while (!cfg[0].tvalid && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("first_slot_arrives", 32'(cfg[0].tvalid), 32'd1);
      check("first_beat_data", cfg[0].tdata, 32'hFFA5F00F);
      check("first_beat_user", 32'(cfg[0].tuser), 32'h0);
      @(negedge clk);
      check("second_beat_data", cfg[0].tdata, 32'h005A0FF0);
      check("second_beat_user", 32'(cfg[0].tuser), 32'h1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rstn   = 1'b0;
      tready = 1'b1;
      fs     = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rstn = 1'b1;

      expect_first_slot();

      // Backpressure across three left/right slots of the 2-line configuration.
      wait_n(200);
      tready = 1'b0;
      wait_n(1000);
      tready = 1'b1;
      check("ovf_after_backpressure", 32'(cfg[0].ovf), 32'd2);

      // Start-of-frame request in the middle of a right slot.
      wait_n(1400);
      fs = 1'b1;
      @(posedge clk);
      #2;
      fs = 1'b0;

      for (int i = 0; i < 1200; i++) begin
         tready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #2;
      end
      tready = 1'b1;

      // Reset while the 2-line configuration sits at bit index 10.
      wait_n(3414);
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rstn = 1'b1;
      expect_first_slot();
      wait_n(800);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
